// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit controller.
//   - op code constants (MDU_MULT .. MDU_MSUB)
//   - controller state enum
//   - DIV_STEPS: number of restoring-division iterations
//   - magnitude(): absolute value helper for signed/unsigned operands
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MSUB  = 3'd7;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  // Accumulate mode for the multiply path (plain load, or HI:LO +/- product).
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_ADD,
    ACC_SUB
  } acc_t;

  // Absolute value when the operand is treated as signed; unchanged otherwise.
  // 0x80000000 maps to itself, which the unsigned divider reads as 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   rem       in  32 : partial remainder so far
//   quot      in  32 : dividend bits still to shift in (MSB first), with
//                      quotient bits collecting at the LSB end
//   divisor   in  32 : divisor magnitude
//   rem_next  out 32 : partial remainder after this step
//   quot_next out 32 : quot shifted left by one, new quotient bit at [0]
module mdu_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quot,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quot_next
);

  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted = {rem, quot[31]};
  // Because rem < divisor, a non-negative difference always fits in 32 bits,
  // so bit 32 is a clean "did not fit" borrow flag.
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    rem_next  = shifted[31:0];
    quot_next = {quot[30:0], 1'b0};
    if (!diff[32]) begin
      rem_next     = diff[31:0];
      quot_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the MIPS execute stage.
// Sequences MULT/MULTU/DIV/DIVU, handles MTHI/MTLO, and owns HI/LO.
//   MULT_LAT       : cycles busy stays high for MULT/MULTU (>=1)
//   clk      in  1 : clock, rising edge
//   rst_n    in  1 : asynchronous active-low reset
//   start    in  1 : E-stage instruction is an MDU op
//   op       in  3 : op code (see mdu_pkg)
//   rs_val   in 32 : first operand / dividend / MTHI-MTLO source
//   rt_val   in 32 : second operand / divisor
//   flush    in  1 : E-stage flush; cancels an op only at its acceptance
//   busy     out 1 : operation in progress (registered)
//   hi       out 32: architectural HI register
//   lo       out 32: architectural LO register
// Optional feature: define MDU_MADD_EN to accept MADD/MSUB (ops 6/7), which
// accumulate the signed product into HI:LO at completion.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_LAT > DIV_STEPS) ? MULT_LAT : DIV_STEPS;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // work_hi:work_lo holds the product during MUL and rem:quot during DIV.
  logic [31:0]        work_hi;
  logic [31:0]        work_lo;
  logic [31:0]        divisor;
  logic [31:0]        dividend;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
`ifdef MDU_MADD_EN
  acc_t               acc;
`endif

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] rem_next;
  logic [31:0] quot_next;
  logic        div_signed;

  // Low 64 bits of the product of 64-bit extended operands are exactly the
  // signed (sign-extended) or unsigned (zero-extended) 32x32 product.
  assign prod_s     = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u     = {32'd0, rs_val} * {32'd0, rt_val};
  assign div_signed = (op == MDU_DIV);

  mdu_div_step u_div_step (
    .rem       (work_hi),
    .quot      (work_lo),
    .divisor   (divisor),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // NOTE: all state uses non-blocking (<=) assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide datapath registers are reset too, so an aborted
      // operation leaves no stale or X state behind.
      state    <= S_IDLE;
      busy     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      cnt      <= '0;
      work_hi  <= 32'd0;
      work_lo  <= 32'd0;
      divisor  <= 32'd0;
      dividend <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`ifdef MDU_MADD_EN
      acc      <= ACC_NONE;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // A flush coinciding with start cancels the op before it is taken.
          if (start && !flush) begin
            case (op)
              MDU_MTHI: hi <= rs_val;
              MDU_MTLO: lo <= rs_val;
              MDU_MULT, MDU_MULTU: begin
                {work_hi, work_lo} <= (op == MDU_MULT) ? prod_s : prod_u;
                cnt   <= CNT_W'(MULT_LAT - 1);
                state <= S_MUL;
                busy  <= 1'b1;
`ifdef MDU_MADD_EN
                acc   <= ACC_NONE;
`endif
              end
`ifdef MDU_MADD_EN
              MDU_MADD, MDU_MSUB: begin
                {work_hi, work_lo} <= prod_s;
                cnt   <= CNT_W'(MULT_LAT - 1);
                state <= S_MUL;
                busy  <= 1'b1;
                acc   <= (op == MDU_MADD) ? ACC_ADD : ACC_SUB;
              end
`endif
              MDU_DIV, MDU_DIVU: begin
                work_hi  <= 32'd0;
                work_lo  <= magnitude(rs_val, div_signed);
                divisor  <= magnitude(rt_val, div_signed);
                dividend <= rs_val;
                neg_q    <= div_signed && (rs_val[31] ^ rt_val[31]);
                neg_r    <= div_signed && rs_val[31];
                div_zero <= (rt_val == 32'd0);
                cnt      <= CNT_W'(DIV_STEPS - 1);
                state    <= S_DIV;
                busy     <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        S_MUL: begin
          if (cnt == '0) begin
`ifdef MDU_MADD_EN
            // Accumulate against HI:LO as they stand at completion.
            case (acc)
              ACC_ADD: {hi, lo} <= {hi, lo} + {work_hi, work_lo};
              ACC_SUB: {hi, lo} <= {hi, lo} - {work_hi, work_lo};
              default: {hi, lo} <= {work_hi, work_lo};
            endcase
`else
            {hi, lo} <= {work_hi, work_lo};
`endif
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_DIV: begin
          work_hi <= rem_next;
          work_lo <= quot_next;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CNT_W'(1);
        end

        S_FIX: begin
          // Signed overflow (0x80000000 / -1) needs no special case: the
          // magnitude quotient 0x80000000 negates to itself, remainder 0.
          if (div_zero) begin
            lo <= 32'hFFFF_FFFF;
            hi <= dividend;
          end else begin
            lo <= neg_q ? (~work_lo + 32'd1) : work_lo;
            hi <= neg_r ? (~work_hi + 32'd1) : work_hi;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (MULT_LAT = 5).
// Covers reset, MULT/MULTU, DIV/DIVU, divide by zero, signed overflow,
// flush at acceptance and mid-operation, back-to-back issue, MADD/MSUB when
// MDU_MADD_EN is defined (ignored op 6/7 otherwise), and reset mid-DIV.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  mdu_ctrl #(.MULT_LAT(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode must stall on busy; a start seen while busy is a protocol error.
  always @(negedge clk) begin
    if (rst_n) assert (!(start && busy)) else $error("protocol violation: start while busy");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge, then return inputs to idle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic f);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    flush  = f;
    step();
    start  = 1'b0;
    flush  = 1'b0;
    op     = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
  endtask

  // Count observed busy cycles from now; bounded so a stuck DUT cannot hang.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    int n;
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mult_busy_rise: got %b want 1", busy);
    end
    count_busy(n);
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL mult_latency: got %0d want 5", n);
    end
    vectors++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA}) begin
      miscompares++;
      $display("FAIL mult_result: got hi=%h lo=%h want hi=ffffffff lo=fffffffa", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    count_busy(n);
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL multu_latency: got %0d want 5", n);
    end
    vectors++;
    if ({hi, lo} !== {32'h0000_0002, 32'hFFFF_FFFA}) begin
      miscompares++;
      $display("FAIL multu_result: got hi=%h lo=%h want hi=00000002 lo=fffffffa", hi, lo);
    end
    // First non-busy cycle: MTLO is accepted and visible one cycle later.
    issue(MDU_MTLO, 32'h0000_1234, 32'd0, 1'b0);
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'h0000_0002, 32'h0000_1234}) begin
      miscompares++;
      $display("FAIL mtlo_b2b: got busy=%b hi=%h lo=%h want busy=0 hi=00000002 lo=00001234",
               busy, hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(n);
    vectors++;
    if (n != 33) begin
      miscompares++;
      $display("FAIL div_latency: got %0d want 33", n);
    end
    vectors++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      miscompares++;
      $display("FAIL div_result: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(MDU_DIVU, 32'h0000_0055, 32'd0, 1'b0);
    count_busy(n);
    vectors++;
    if (n != 33) begin
      miscompares++;
      $display("FAIL divu_zero_latency: got %0d want 33", n);
    end
    vectors++;
    if ({hi, lo} !== {32'h0000_0055, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL divu_zero_result: got hi=%h lo=%h want hi=00000055 lo=ffffffff", hi, lo);
    end
    // Signed divide by zero keeps the raw (negative) dividend in HI.
    issue(MDU_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
    count_busy(n);
    vectors++;
    if ({n, hi, lo} !== {32'd33, 32'hFFFF_FF00, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL div_zero_signed: got cycles=%0d hi=%h lo=%h want cycles=33 hi=ffffff00 lo=ffffffff",
               n, hi, lo);
    end
  endtask

  task automatic test_overflow();
    int n;
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    vectors++;
    if ({n, hi, lo} !== {32'd33, 32'h0000_0000, 32'h8000_0000}) begin
      miscompares++;
      $display("FAIL div_overflow: got cycles=%0d hi=%h lo=%h want cycles=33 hi=00000000 lo=80000000",
               n, hi, lo);
    end
  endtask

  task automatic test_flush();
    int n;
    // State entering: hi=0, lo=0x80000000.
    issue(MDU_MTHI, 32'h0000_00AA, 32'd0, 1'b1);
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'h0000_0000, 32'h8000_0000}) begin
      miscompares++;
      $display("FAIL flush_mthi: got busy=%b hi=%h lo=%h want busy=0 hi=00000000 lo=80000000",
               busy, hi, lo);
    end
    issue(MDU_MULT, 32'd5, 32'd5, 1'b1);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_mult_accept: got busy=%b want 0", busy);
    end
    // Flush pulse in the middle of an accepted DIV: the result still commits.
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    count_busy(n);
    vectors++;
    if (n != 29) begin
      miscompares++;
      $display("FAIL flush_div_latency: got %0d remaining cycles want 29", n);
    end
    vectors++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      miscompares++;
      $display("FAIL flush_div_result: got hi=%h lo=%h want hi=00000002 lo=0000000e", hi, lo);
    end
  endtask

  task automatic test_madd();
    int n;
    issue(MDU_MTHI, 32'd0, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'd10, 32'd0, 1'b0);
    issue(MDU_MADD, 32'd3, 32'd4, 1'b0);
    count_busy(n);
`ifdef MDU_MADD_EN
    vectors++;
    if ({n, hi, lo} !== {32'd5, 32'd0, 32'd22}) begin
      miscompares++;
      $display("FAIL madd: got cycles=%0d hi=%h lo=%h want cycles=5 hi=0 lo=22", n, hi, lo);
    end
    issue(MDU_MSUB, 32'd5, 32'd5, 1'b0);
    count_busy(n);
    vectors++;
    // 22 - 25 = -3 borrows through into HI.
    if ({n, hi, lo} !== {32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      miscompares++;
      $display("FAIL msub: got cycles=%0d hi=%h lo=%h want cycles=5 hi=ffffffff lo=fffffffd",
               n, hi, lo);
    end
`else
    vectors++;
    if ({n, hi, lo} !== {32'd0, 32'd0, 32'd10}) begin
      miscompares++;
      $display("FAIL op6_ignored: got cycles=%0d hi=%h lo=%h want cycles=0 hi=0 lo=10", n, hi, lo);
    end
    issue(MDU_MSUB, 32'd5, 32'd5, 1'b0);
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd10}) begin
      miscompares++;
      $display("FAIL op7_ignored: got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=10", busy, hi, lo);
    end
`endif
  endtask

  task automatic test_reset_mid_div();
    int n;
    issue(MDU_MTHI, 32'h0000_0077, 32'd0, 1'b0);
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_div: got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, hi, lo);
    end
    step();
    rst_n = 1'b1;
    step();
    issue(MDU_MTLO, 32'h0000_5A5A, 32'd0, 1'b0);
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'd0, 32'h0000_5A5A}) begin
      miscompares++;
      $display("FAIL post_reset_mtlo: got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=00005a5a",
               busy, hi, lo);
    end
    issue(MDU_MULTU, 32'd7, 32'd6, 1'b0);
    count_busy(n);
    vectors++;
    if ({n, hi, lo} !== {32'd5, 32'd0, 32'd42}) begin
      miscompares++;
      $display("FAIL post_reset_multu: got cycles=%0d hi=%h lo=%h want cycles=5 hi=0 lo=42",
               n, hi, lo);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    op          = 3'd0;
    rs_val      = 32'd0;
    rt_val      = 32'd0;
    flush       = 1'b0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();

    test_mult();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_overflow();
    test_flush();
    test_madd();
    test_reset_mid_div();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the execute stage of the MIPS pipeline. It accepts the HI/LO-class instructions passed by the decode stage (MULT, MULTU, DIV, DIVU, MTHI, MTLO), sequences multi-cycle execution, and owns the architectural HI and LO registers. It raises `busy` so the decode-stage hazard logic can stall any following HI/LO-class instruction (MFHI, MFLO and the ops above) until the result has been committed.

## Interface
- `MULT_LAT`, default 5: cycles `busy` stays high for MULT/MULTU (≥1).
- `clk`  in  1: the single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: the E-stage instruction is an MDU op; sampled on the rising edge.
- `op`  in  3: op code.
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 MADD, 7 MSUB, only under the macro below.
- `rs_val`  in  32: first operand; dividend for DIV/DIVU; the source for MTHI/MTLO.
- `rt_val`  in  32: second operand; divisor for DIV/DIVU.
- `flush`  in  1: exception or ERET flush of the E stage.
- `busy`  out  1: an operation is in progress.
- `hi`  out  32: architectural HI register.
- `lo`  out  32: architectural LO register.

## Operation
- **Reset:** state IDLE; `busy`=0, `hi`=0, `lo`=0, counter=0. Reset asserted mid-operation discards the operation immediately.
- **States:** IDLE, MUL, DIV, FIX.
- **IDLE:**
  - `start` with `flush`=0 and op MTHI/MTLO: write `rs_val` to HI/LO at that edge; stay IDLE.
  - `start` with op MULT/MULTU: latch the full 64-bit product (signed or unsigned), load counter = `MULT_LAT`-1, go to MUL.
  - `start` with op DIV/DIVU: latch magnitudes and sign flags (DIVU: signs = 0), counter = 31, go to DIV.
  - Undefined op codes are ignored.
- **MUL:** decrement the counter; at 0 write HI = product[63:32], LO = product[31:0], go to IDLE.
- **DIV:** one restoring-division step per cycle on the 32-bit magnitudes; at counter 0 go to FIX.
- **FIX:**
  - Apply signs: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Write LO = quotient, HI = remainder; go to IDLE.
- **Divide by zero:** LO = 0xFFFFFFFF, HI = `rs_val`, for both signed and unsigned; latency is unchanged.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- **`start` while `busy`=1:** ignored. Decode must stall on `busy`, so this condition is a protocol violation; the bench flags it with an assertion.
- **`flush` with `start` in IDLE:** the op is not accepted, and HI/LO are unchanged, including for MTHI/MTLO.
- **`flush` while `busy`:**
  - An operation is cancelled only if `flush` coincides with its acceptance.
  - Once accepted, an operation completes, matching MIPS semantics where an issued mult/div commits.
  - `flush` has no effect in MUL/DIV/FIX.

## Timing
- `start` sampled at edge T. `busy` is registered and goes high for cycle T+1.
- MULT/MULTU: `busy` high for `MULT_LAT` cycles. HI/LO are updated at the edge that drops `busy`, and the new values are visible in the first cycle with `busy`=0.
- DIV/DIVU: `busy` high for 33 cycles (32 DIV + 1 FIX); same update rule.
- MTHI/MTLO: `busy` is never asserted; the new value is visible at T+1.
- A new `start` may be accepted in the first cycle `busy`=0 (back-to-back issue).
- `hi` and `lo` are direct register outputs with no combinational path from the inputs.

## Configuration
- Macro `MDU_MADD_EN`.
- **Defined:** ops 6/7 (MADD/MSUB, signed) are accepted.
  - Same timing as MULT.
  - At completion: {HI,LO} = {HI,LO} ± product, using the HI/LO values present at completion.
- **Undefined:** op codes 6/7 are ignored like any undefined code; the accumulate adder is not built.

## Structure
- **Shared package `mdu_pkg`:**
  - op code constants (`MDU_MULT` … `MDU_MSUB`)
  - state enum
  - `DIV_STEPS` = 32
- **Sub-module `mdu_div_step`:** one combinational restoring step, taking {rem, quot, divisor} and producing next {rem, quot}. It is instantiated once and iterated by the controller.
- **Controller:** the FSM, counter, sign fixup, HI/LO registers, and the optional MADD accumulate.

## Test plan
- **Reset:** reset asserted mid-DIV → `busy`=0, `hi`=`lo`=0 immediately; after release, IDLE accepts a new `start`.
- **MULT:** MULT rs=0xFFFFFFFE (−2), rt=3 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **MULTU, back-to-back MTLO:** MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA. An MTLO 0x1234 issued in the first non-busy cycle gives LO=0x1234 one cycle later.
- **DIV:** DIV rs=−7 (0xFFFFFFF9), rt=2 → `busy` 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **DIVU by zero:** DIVU rs=0x55, rt=0 → LO=0xFFFFFFFF, HI=0x55 after 33 cycles.
- **Flush:**
  - `flush`+`start`(MTHI 0xAA) → HI unchanged, `busy`=0.
  - `flush` pulse during an in-flight DIV → the result still commits.
  - With `MDU_MADD_EN`: HI:LO = 0:10, MADD 3×4 → LO = 22.
